instruction_memory: RTL and testbench

INSTRUCTION_MEMORY -- requirements
Module: instruction_memory

---
 rtl/riscv_pkg.sv | 23 ++
 rtl/resp_fifo.sv | 59 +++++
 rtl/instruction_memory.sv | 129 ++++++++++++
 tb/tb_instruction_memory.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V fetch-side definitions: word width, canonical NOP,
// default instruction memory depth and the response record format.
package riscv_pkg;

  localparam int XLEN = 32;

  // addi x0, x0, 0 -- returned in place of data on a faulting fetch
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  localparam int IMEM_DEPTH_DEFAULT = 1024;

  // One fetch response: error flag plus instruction word (33 bits)
  typedef struct packed {
    logic            err;
    logic [XLEN-1:0] data;
  } imem_rsp_t;

  // Instructions are word aligned; any low address bit set is a fault
  function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/resp_fifo.sv
// Two-entry response queue holding fetch responses that the consumer
// has not yet taken. Flush empties it in a single cycle.
module resp_fifo
  import riscv_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic       flush,
  input  imem_rsp_t  wdata,
  output imem_rsp_t  rdata,
  output logic       full,
  output logic       empty,
  output logic [1:0] count
);

  imem_rsp_t  mem [0:1];
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] cnt;
  logic       do_push;
  logic       do_pop;

  assign empty   = (cnt == 2'd0);
  assign full    = (cnt == 2'd2);
  assign count   = cnt;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  // Entry storage write
  // NOTE: storage is not reset; pointers and count alone define which entries are live.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/instruction_memory.sv
// Read-only instruction memory with a valid/ready fetch interface.
// One read is in flight per cycle; responses not taken immediately are
// parked in a two-entry queue. Total outstanding responses never exceed 2.
module instruction_memory
  import riscv_pkg::*;
#(
  parameter int              DEPTH_WORDS = IMEM_DEPTH_DEFAULT,
  parameter logic [XLEN-1:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [XLEN-1:0] req_addr,
  input  logic            flush,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_data,
  output logic            rsp_err
);

  localparam int              IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [XLEN-1:0] DEPTH_LIM = XLEN'(DEPTH_WORDS);

  // Program image; loaded from outside, never written by this block
  logic [XLEN-1:0] imem [0:DEPTH_WORDS-1];

  logic [XLEN-1:0] offset;
  logic            below_base;
  logic            beyond_end;
  logic            req_err;
  logic [IDX_W-1:0] idx;
  imem_rsp_t       rd_rsp;

  logic            accept;
  logic            rsp_pop;
  logic [1:0]      occ;

  logic            infl_valid;
  imem_rsp_t       infl_rsp;

  logic            fifo_push;
  logic            fifo_pop;
  logic            fifo_full;
  logic            fifo_empty;
  logic [1:0]      fifo_count;
  imem_rsp_t       fifo_rdata;
  imem_rsp_t       out_rsp;

  // Address decode: word index relative to BASE_ADDR and fault detection
  assign offset     = req_addr - BASE_ADDR;
  assign below_base = (req_addr < BASE_ADDR);
  assign beyond_end = ({2'b00, offset[XLEN-1:2]} >= DEPTH_LIM);
  assign req_err    = is_misaligned(req_addr) || below_base || beyond_end;
  assign idx        = offset[IDX_W+1:2];

  // Read mux: faulting fetches return a NOP and never touch imem
  always_comb begin
    // NOTE: default assignment first so no branch can leave rd_rsp latched.
    rd_rsp = '0;
    if (req_err) rd_rsp = imem_rsp_t'{err: 1'b1, data: NOP_INSTR};
    else         rd_rsp = imem_rsp_t'{err: 1'b0, data: imem[idx]};
  end

  // Ready depends only on registered occupancy, never on rsp_ready
  assign req_ready = !rst && !flush && (occ < 2'd2);
  assign accept    = req_valid && req_ready;
  assign rsp_pop   = rsp_valid && rsp_ready && !flush;

  // In-flight read stage: holds the word read on the accepting edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      infl_valid <= 1'b0;
      infl_rsp   <= '0;
    end else if (flush) begin
      infl_valid <= 1'b0;
    end else begin
      infl_valid <= accept;
      if (accept) infl_rsp <= rd_rsp;
    end
  end

  // Outstanding-response counter (in-flight plus queued)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ <= 2'd0;
    end else if (flush) begin
      occ <= 2'd0;
    end else begin
      case ({accept, rsp_pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

  // Queued entries are older than the in-flight one, so the queue head
  // is presented first; the in-flight word bypasses the queue only when
  // the queue is empty and the consumer takes it straight away.
  assign fifo_pop  = !fifo_empty && rsp_ready;
  assign fifo_push = infl_valid && !(fifo_empty && rsp_ready);

  resp_fifo u_resp_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (flush),
    .wdata (infl_rsp),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign out_rsp   = fifo_empty ? infl_rsp : fifo_rdata;
  assign rsp_valid = infl_valid || !fifo_empty;
  assign rsp_data  = out_rsp.data;
  assign rsp_err   = out_rsp.err;

  // The counter must agree with the physical storage holding responses
  a_occ_consistent: assert property (@(posedge clk) disable iff (rst)
    occ == ({1'b0, infl_valid} + fifo_count));

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(fifo_full && infl_valid));

endmodule

// File: tb/tb_instruction_memory.sv
// Bench for instruction_memory: table of single fetches plus hand-written
// back-to-back, backpressure, flush and reset sequences, all checked
// through an in-order scoreboard.
module tb_instruction_memory;
  import riscv_pkg::*;

  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic        flush = 1'b0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic        rsp_err;

  int checks   = 0;
  int failures = 0;

  imem_rsp_t sb[$];
  imem_rsp_t cur_exp = '0;

  logic [31:0] prog [4] = '{32'h0050_0093, 32'h00A0_0113, 32'h0020_81B3, 32'h0000_0013};

  typedef struct {
    logic [31:0] addr;
    logic        exp_err;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs [10];

  instruction_memory #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(32'h0000_0000)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .flush     (flush),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: sampled mid-cycle, so what it sees is what the
  // next rising edge will act on.
  logic      prev_hold = 1'b0;
  imem_rsp_t prev_rsp  = '0;

  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      prev_hold = 1'b0;
    end else begin
      check("occupancy", 64'(dut.occ), 64'(sb.size()));
      check("occ_range", 64'(dut.occ <= 2'd2), 64'd1);
      if (prev_hold)
        check("hold_stable", {rsp_valid, rsp_err, rsp_data}, {1'b1, prev_rsp});
      if (flush) begin
        sb.delete();
      end else begin
        if (rsp_valid && rsp_ready) begin
          check("rsp_expected", 64'(sb.size() != 0), 64'd1);
          if (sb.size() != 0) begin
            check("rsp_order", 64'({rsp_err, rsp_data}), 64'(sb[0]));
            void'(sb.pop_front());
          end
        end
        if (req_valid && req_ready) sb.push_back(cur_exp);
      end
      prev_hold = rsp_valid && !rsp_ready && !flush;
      prev_rsp  = imem_rsp_t'{err: rsp_err, data: rsp_data};
    end
  end

  // Present one request until accepted; returns at posedge+1 with req_valid low
  task automatic issue(input logic [31:0] a, input imem_rsp_t e);
    bit ok = 1'b0;
    req_addr  = a;
    cur_exp   = e;
    req_valid = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (req_ready) begin
        ok = 1'b1;
        break;
      end
    end
    check("accept_timeout", 64'(ok), 64'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  // Wait (bounded) until every expected response has been consumed
  task automatic wait_drain();
    for (int n = 0; n < 30; n++) begin
      @(posedge clk);
      #1;
      if (sb.size() == 0 && !rsp_valid) break;
    end
    check("drain", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{addr: 32'h0000_0000, exp_err: 1'b0, exp_data: 32'h0050_0093};
    vecs[1] = '{addr: 32'h0000_0002, exp_err: 1'b1, exp_data: NOP_INSTR};
    vecs[2] = '{addr: 32'h0000_0004, exp_err: 1'b0, exp_data: 32'h00A0_0113};
    vecs[3] = '{addr: 4 * DEPTH,     exp_err: 1'b1, exp_data: NOP_INSTR};
    vecs[4] = '{addr: 32'h0000_00FC, exp_err: 1'b0, exp_data: 32'hC0DE_003F};
    vecs[5] = '{addr: 32'h0000_0010, exp_err: 1'b0, exp_data: 32'hC0DE_0004};
    vecs[6] = '{addr: 32'hFFFF_FFFC, exp_err: 1'b1, exp_data: NOP_INSTR};
    vecs[7] = '{addr: 32'h0000_0101, exp_err: 1'b1, exp_data: NOP_INSTR};
    vecs[8] = '{addr: 32'h0000_0009, exp_err: 1'b1, exp_data: NOP_INSTR};
    vecs[9] = '{addr: 32'h0000_000C, exp_err: 1'b0, exp_data: 32'h0000_0013};

    for (int i = 0; i < DEPTH; i++) dut.imem[i] = 32'hC0DE_0000 | 32'(i);
    for (int i = 0; i < 4; i++) dut.imem[i] = prog[i];

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_outputs", {rsp_valid, rsp_err, rsp_data}, 64'd0);
    @(negedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    // Back-to-back fetch of the four program words with 1-cycle latency
    rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) begin
        req_valid = 1'b1;
        req_addr  = 32'(4 * i);
        cur_exp   = imem_rsp_t'{err: 1'b0, data: prog[i]};
      end else begin
        req_valid = 1'b0;
      end
      @(negedge clk);
      if (i < 4) check("b2b_ready", 64'(req_ready), 64'd1);
      if (i > 0) check("b2b_latency", {rsp_valid, rsp_err, rsp_data}, {1'b1, 1'b0, prog[i-1]});
      @(posedge clk);
      #1;
    end
    wait_drain();

    // Backpressure: two accepted, third held off, head stays stable
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_addr  = 32'h0;
    cur_exp   = imem_rsp_t'{err: 1'b0, data: prog[0]};
    @(posedge clk);
    #1;
    req_addr = 32'h4;
    cur_exp  = imem_rsp_t'{err: 1'b0, data: prog[1]};
    @(posedge clk);
    #1;
    req_addr = 32'h8;
    cur_exp  = imem_rsp_t'{err: 1'b0, data: prog[2]};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("full_ready_low", 64'(req_ready), 64'd0);
      check("stall_head", {rsp_valid, rsp_err, rsp_data}, {1'b1, 1'b0, prog[0]});
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    @(negedge clk);
    check("no_comb_ready", 64'(req_ready), 64'd0);
    check("pop_head", {rsp_valid, rsp_err, rsp_data}, {1'b1, 1'b0, prog[0]});
    @(posedge clk);
    #1;
    @(negedge clk);
    check("second_rsp", {rsp_valid, rsp_err, rsp_data}, {1'b1, 1'b0, prog[1]});
    check("third_ready", 64'(req_ready), 64'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    wait_drain();

    // Table of single fetches, including misaligned and out-of-range
    for (int i = 0; i < 10; i++)
      issue(vecs[i].addr, imem_rsp_t'{err: vecs[i].exp_err, data: vecs[i].exp_data});
    wait_drain();

    // Flush with two outstanding responses
    rsp_ready = 1'b0;
    issue(32'h0, imem_rsp_t'{err: 1'b0, data: prog[0]});
    issue(32'h4, imem_rsp_t'{err: 1'b0, data: prog[1]});
    flush = 1'b1;
    @(negedge clk);
    check("flush_ready_low", 64'(req_ready), 64'd0);
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    check("flush_valid", 64'(rsp_valid), 64'd0);
    check("flush_occ", 64'(dut.occ), 64'd0);
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    issue(32'h8, imem_rsp_t'{err: 1'b0, data: prog[2]});
    wait_drain();

    // Flush and rsp_ready together: flush wins
    rsp_ready = 1'b0;
    issue(32'hC, imem_rsp_t'{err: 1'b0, data: prog[3]});
    issue(32'h10, imem_rsp_t'{err: 1'b0, data: 32'hC0DE_0004});
    flush     = 1'b1;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    check("flush_pop_valid", 64'(rsp_valid), 64'd0);
    check("flush_pop_occ", 64'(dut.occ), 64'd0);
    @(posedge clk);
    #1;
    issue(32'h0, imem_rsp_t'{err: 1'b0, data: prog[0]});
    wait_drain();

    // Reset while a response is pending
    rsp_ready = 1'b0;
    issue(32'h4, imem_rsp_t'{err: 1'b0, data: prog[1]});
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("rst_async_out", {req_ready, rsp_valid, rsp_err, rsp_data}, 64'd0);
    check("rst_async_occ", 64'(dut.occ), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_ready", 64'(req_ready), 64'd1);
    rsp_ready = 1'b1;
    issue(32'h0, imem_rsp_t'{err: 1'b0, data: prog[0]});
    wait_drain();

    repeat (2) @(posedge clk);
    #1;
    check("sb_empty_end", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
